// File: rtl/siso_frame_pkg.sv
// ============================================================================
// Module : siso_frame_pkg
// Brief  : FSM state encodings and counter sizing for siso_frame_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package siso_frame_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Counter must reach WIDTH+DEPTH-1 without wrapping.
  function automatic int cnt_width(input int width, input int depth);
    return $clog2(width + depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/siso_chain.sv
// ============================================================================
// Module : siso_chain
// Brief  : DEPTH-stage enabled serial shift chain with async active-low clear.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module siso_chain #(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             d,
  output logic [DEPTH-1:0] q
);

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d = stage_q;
    if (en) begin
      stage_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q;

endmodule

`default_nettype wire

// File: rtl/siso_frame_ctrl.sv
// ============================================================================
// Module : siso_frame_ctrl
// Brief  : Serialises a parallel word LSB-first through a SISO chain, flushes
//          it, and reassembles the chain tail into a parallel output word.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module siso_frame_ctrl
  import siso_frame_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             ser_in,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH, DEPTH);

  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(WIDTH + DEPTH - 1);
  localparam logic [CNT_W-1:0] CAP_START  = CNT_W'(DEPTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic             ready_q, ready_d;

  logic             chain_en;
  logic             ser_bit;
  logic [DEPTH-1:0] chain_q;
  logic [DEPTH-1:0] unused_chain_q;
  logic             q_tail;
  logic [WIDTH:0]   rx_cat;

  siso_chain #(
    .DEPTH (DEPTH)
  ) u_chain (
    .clk (clk),
    .clr (clr),
    .en  (chain_en),
    .d   (ser_bit),
    .q   (chain_q)
  );

  // Only the tail stage feeds the controller; the rest is observe-only.
  assign unused_chain_q = chain_q;
  assign q_tail         = chain_q[DEPTH-1];
  assign rx_cat         = {q_tail, rx_sr_q};

  // Holds in_ready low until the first edge after reset release.
  assign ready_d = 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tx_sr_d  = tx_sr_q;
    rx_sr_d  = rx_sr_q;
    chain_en = 1'b0;
    ser_bit  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && ready_q) begin
          tx_sr_d = in_data;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        chain_en = 1'b1;
        ser_bit  = tx_sr_q[0];
        tx_sr_d  = tx_sr_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_SHIFT) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        chain_en = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_FLUSH) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    // The first bit reaches the tail DEPTH edges after it entered the chain.
    if (chain_en && (cnt_q >= CAP_START)) begin
      rx_sr_d = rx_cat[WIDTH:1];
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready  = ready_q && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = (state_q == ST_DONE) ? rx_sr_q : '0;
  assign ser_in    = ser_bit;
  assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_siso_frame_ctrl.sv
// ============================================================================
// Module : tb_siso_frame_ctrl
// Brief  : Directed-vector bench for siso_frame_ctrl (WIDTH=8, DEPTH=3).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_siso_frame_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             clk;
  logic             clr;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             ser_in;
  logic             busy;

  int n_vec;
  int n_err;

  siso_frame_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .ser_in    (ser_in),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input string tag, input logic [WIDTH-1:0] d);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic take_word(input string tag, input logic [WIDTH-1:0] exp);
    int n;
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_dat"}, 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [10:0] ser_exp;
  int          nacc, nout, vcnt;
  int          acc_t [2];
  logic [7:0]  outs  [2];
  logic        acc_seen, out_seen;

  initial begin
    n_vec     = 0;
    n_err     = 0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // 1. reset state
    tick();
    tick();
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_ser_in",    32'(ser_in),    32'd0);
    clr = 1'b1;
    tick();
    chk("rel_in_ready",  32'(in_ready),  32'd1);

    // 2. A5: serial sequence, 11-cycle latency
    ser_exp = 11'b000_1010_0101;
    send_word("a5", 8'hA5);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("a5_ser%0d", i), 32'(ser_in), 32'(ser_exp[i]));
      chk($sformatf("a5_nov%0d", i), 32'(out_valid), 32'd0);
      tick();
    end
    chk("a5_lat_vld", 32'(out_valid), 32'd1);
    chk("a5_busy",    32'(busy),      32'd1);
    take_word("a5", 8'hA5);
    chk("a5_idle_rdy", 32'(in_ready), 32'd1);

    // 3. 5A with consumer stalled for 5 cycles
    send_word("5a", 8'h5A);
    repeat (11) tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("5a_hold_vld%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("5a_hold_dat%0d", i), 32'(out_data),  32'h5A);
      chk($sformatf("5a_hold_rdy%0d", i), 32'(in_ready),  32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("5a_rel_vld", 32'(out_valid), 32'd0);
    chk("5a_rel_rdy", 32'(in_ready),  32'd1);

    // 4. in_valid with FF held while busy is ignored
    send_word("3c", 8'h3C);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (11) tick();
    chk("3c_vld",  32'(out_valid), 32'd1);
    chk("3c_dat",  32'(out_data),  32'h3C);
    chk("3c_rdy",  32'(in_ready),  32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    chk("3c_no_ff", 32'(busy), 32'd0);

    // 5. async clear mid-SHIFT of F0
    send_word("f0", 8'hF0);
    repeat (4) tick();
    chk("f0_ser_pre", 32'(ser_in), 32'd1);
    chk("f0_busy_pre", 32'(busy), 32'd1);
    clr = 1'b0;
    #1;
    chk("clr_busy",      32'(busy),      32'd0);
    chk("clr_ser_in",    32'(ser_in),    32'd0);
    chk("clr_in_ready",  32'(in_ready),  32'd0);
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_out_data",  32'(out_data),  32'd0);
    tick();
    clr = 1'b1;
    chk("clr_rel_rdy0", 32'(in_ready), 32'd0);
    tick();
    chk("clr_rel_rdy1", 32'(in_ready), 32'd1);
    vcnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) vcnt++;
      tick();
    end
    chk("clr_no_out", 32'(vcnt), 32'd0);
    send_word("81", 8'h81);
    take_word("81", 8'h81);

    // 6. back-to-back with both sides always ready
    nacc      = 0;
    nout      = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h01;
    for (int c = 0; c < 60 && nout < 2; c++) begin
      acc_seen = in_valid && in_ready;
      out_seen = out_valid && out_ready;
      if (out_seen) outs[nout] = out_data;
      tick();
      if (acc_seen) begin
        acc_t[nacc] = c;
        nacc++;
        if (nacc == 1) in_data = 8'h80;
        else           in_valid = 1'b0;
      end
      if (out_seen) nout++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_nacc", 32'(nacc), 32'd2);
    chk("b2b_nout", 32'(nout), 32'd2);
    if (nacc == 2) chk("b2b_period", 32'(acc_t[1] - acc_t[0]), 32'd13);
    if (nout == 2) begin
      chk("b2b_out0", 32'(outs[0]), 32'h01);
      chk("b2b_out1", 32'(outs[1]), 32'h80);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
